// File: rtl/hmac_stream_driver.sv
// ---------------------------------------------------------------------------
// hmac_stream_driver
//
// Host-side front end for the hmac core. One job is collected from a byte
// stream (1 header byte, 128 key bytes, 64 message bytes, all MSB first),
// presented to the core, and the core is released from reset to run. Once
// the core reports done, the 512-bit result is streamed back out as 64
// bytes, MSB first. Only one job is in flight at a time.
//
// Optional build macro:
//   HMAC_DRV_TIMEOUT_EN - adds a RUN watchdog. If the core has not reported
//                         done after TIMEOUT_CYCLES RUN cycles, err is set
//                         (sticky until the next header byte) and 64 zero
//                         bytes are emitted in place of a result.
//                         Without it, err is tied low and RUN waits forever.
//
// Ports:
//   clk        in   1     system clock, all logic on posedge
//   reset      in   1     asynchronous active-low reset
//   in_valid   in   1     input byte valid
//   in_ready   out  1     driver can accept an input byte
//   in_data    in   8     input byte
//   out_valid  out  1     result byte valid
//   out_ready  in   1     sink accepts the result byte
//   out_data   out  8     result byte
//   out_last   out  1     marks the 64th result byte
//   busy       out  1     job in progress (header accepted .. last byte out)
//   err        out  1     sticky watchdog flag
//   core_reset out  1     active-low reset to the hmac core (1 = run)
//   core_done  in   1     hmac done
//   core_mode  out  1     hmac mode
//   core_key   out  1024  hmac key
//   core_msg   out  512   hmac message
//   core_oH    in   512   hmac result
// ---------------------------------------------------------------------------
module hmac_stream_driver #(
    parameter int HOLD_CYCLES    = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err,
    output logic          core_reset,
    input  logic          core_done,
    output logic          core_mode,
    output logic [1023:0] core_key,
    output logic [511:0]  core_msg,
    input  logic [511:0]  core_oH
);

    typedef enum logic [2:0] {
        S_LOAD_HDR = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_MSG = 3'd2,
        S_HOLD     = 3'd3,
        S_RUN      = 3'd4,
        S_SEND     = 3'd5
    } state_t;

    state_t          r_state;
    logic [31:0]     r_cnt;        // byte counter, hold counter and watchdog
    logic            r_run_first;  // first RUN cycle: core_done is not trusted yet
    logic [511:0]    r_sr;         // result shift register
    logic            r_in_ready;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic            r_busy;
    logic            r_core_reset;
    logic            r_core_mode;
    logic [1023:0]   r_core_key;
    logic [511:0]    r_core_msg;

    logic            w_in_xfer;
    logic            w_out_xfer;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

`ifdef HMAC_DRV_TIMEOUT_EN
    logic            r_err;
    assign err = r_err;
`else
    logic            w_unused_timeout;
    assign err              = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Job sequencer: load, hold core in reset, run, stream result back out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LOAD_HDR;
            r_cnt        <= 32'd0;
            r_run_first  <= 1'b0;
            r_sr         <= 512'd0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'd0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_core_reset <= 1'b0;
            r_core_mode  <= 1'b0;
            r_core_key   <= 1024'd0;
            r_core_msg   <= 512'd0;
`ifdef HMAC_DRV_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD_HDR: begin
                    // in_ready comes up here on the first cycle after reset release
                    r_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        r_core_mode <= in_data[0];
                        r_busy      <= 1'b1;
                        r_cnt       <= 32'd0;
                        r_state     <= S_LOAD_KEY;
`ifdef HMAC_DRV_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
                end

                S_LOAD_KEY: begin
                    if (w_in_xfer) begin
                        r_core_key <= {r_core_key[1015:0], in_data};
                        if (r_cnt == 32'd127) begin
                            r_cnt   <= 32'd0;
                            r_state <= S_LOAD_MSG;
                        end else begin
                            r_cnt   <= r_cnt + 32'd1;
                        end
                    end
                end

                S_LOAD_MSG: begin
                    if (w_in_xfer) begin
                        r_core_msg <= {r_core_msg[503:0], in_data};
                        if (r_cnt == 32'd63) begin
                            r_cnt      <= 32'd0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_HOLD;
                        end else begin
                            r_cnt      <= r_cnt + 32'd1;
                        end
                    end
                end

                S_HOLD: begin
                    // core_reset rises on the same edge that enters RUN
                    if (r_cnt == 32'(HOLD_CYCLES - 1)) begin
                        r_cnt        <= 32'd0;
                        r_core_reset <= 1'b1;
                        r_run_first  <= 1'b1;
                        r_state      <= S_RUN;
                    end else begin
                        r_cnt        <= r_cnt + 32'd1;
                    end
                end

                S_RUN: begin
                    r_run_first <= 1'b0;
                    if (!r_run_first && core_done) begin
                        r_sr         <= core_oH;
                        r_out_data   <= core_oH[511:504];
                        r_out_valid  <= 1'b1;
                        r_out_last   <= 1'b0;
                        r_core_reset <= 1'b0;
                        r_cnt        <= 32'd0;
                        r_state      <= S_SEND;
                    end else begin
`ifdef HMAC_DRV_TIMEOUT_EN
                        // Watchdog expiry: abandon the core and emit a zero result
                        if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                            r_err        <= 1'b1;
                            r_sr         <= 512'd0;
                            r_out_data   <= 8'd0;
                            r_out_valid  <= 1'b1;
                            r_out_last   <= 1'b0;
                            r_core_reset <= 1'b0;
                            r_cnt        <= 32'd0;
                            r_state      <= S_SEND;
                        end else begin
                            r_cnt        <= r_cnt + 32'd1;
                        end
`else
                        r_cnt <= r_cnt;
`endif
                    end
                end

                S_SEND: begin
                    if (w_out_xfer) begin
                        if (r_cnt == 32'd63) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= 8'd0;
                            r_busy      <= 1'b0;
                            r_cnt       <= 32'd0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD_HDR;
                        end else begin
                            // next byte is pre-loaded so out_data stays registered
                            r_sr        <= {r_sr[503:0], 8'd0};
                            r_out_data  <= r_sr[503:496];
                            r_out_last  <= (r_cnt == 32'd62);
                            r_cnt       <= r_cnt + 32'd1;
                        end
                    end
                end

                default: begin
                    r_state      <= S_LOAD_HDR;
                    r_cnt        <= 32'd0;
                    r_in_ready   <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_out_last   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_core_reset <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign core_reset = r_core_reset;
    assign core_mode  = r_core_mode;
    assign core_key   = r_core_key;
    assign core_msg   = r_core_msg;

endmodule

// File: tb/tb_hmac_stream_driver.sv
// ---------------------------------------------------------------------------
// tb_hmac_stream_driver
//
// Directed sequence with randomized data, gaps and sink backpressure. A stub
// hmac core raises done 10 cycles after its reset is released and returns a
// bench-chosen result. Expected key/message/result bytes come from simple
// byte-array models; the HMAC_DRV_TIMEOUT_EN section runs only when the
// macro is defined.
// ---------------------------------------------------------------------------
module tb_hmac_stream_driver;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;
    logic          err;
    logic          core_reset;
    logic          core_done = 1'b0;
    logic          core_mode;
    logic [1023:0] core_key;
    logic [511:0]  core_msg;
    logic [511:0]  core_oH;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [7:0]    kb [128];
    logic [7:0]    mb [64];
    logic [7:0]    hdr_b;
    logic [511:0]  oh_v;
    int            stub_cnt = 0;
    logic          never_done = 1'b0;

    always #5 clk = ~clk;

    hmac_stream_driver #(
        .HOLD_CYCLES    (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err),
        .core_reset (core_reset),
        .core_done  (core_done),
        .core_mode  (core_mode),
        .core_key   (core_key),
        .core_msg   (core_msg),
        .core_oH    (core_oH)
    );

    // Stub hmac core: done rises 10 cycles after its reset is released
    always @(posedge clk) begin
        if (!core_reset) begin
            stub_cnt  <= 0;
            core_done <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 9 && !never_done) core_done <= 1'b1;
        end
    end

    function automatic logic [1023:0] model_key();
        logic [1023:0] k;
        k = 1024'd0;
        for (int i = 0; i < 128; i++) k[1023 - 8*i -: 8] = kb[i];
        return k;
    endfunction

    function automatic logic [511:0] model_msg();
        logic [511:0] m;
        m = 512'd0;
        for (int i = 0; i < 64; i++) m[511 - 8*i -: 8] = mb[i];
        return m;
    endfunction

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int t;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 1000) begin @(posedge clk); #1; t++; end
        if (t >= 1000) begin
            n_tests++;
            n_fail++;
            $error("FAIL in_ready_wait: observed %0b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_body(input int gap);
        for (int i = 0; i < 128; i++) send_byte(kb[i], gap);
        for (int i = 0; i < 64; i++)  send_byte(mb[i], gap);
    endtask

    // Returns the number of cycles core_reset stayed low after the call
    task automatic wait_run(output int n);
        n = 0;
        while (!core_reset && n < 500) begin @(posedge clk); #1; n++; end
    endtask

    task automatic recv_job(input logic [511:0] exp_oh, input bit rand_ready);
        int idx;
        int t;
        bit holding;
        logic [7:0] held_d;
        logic held_l;
        idx = 0; t = 0; holding = 1'b0; held_d = 8'd0; held_l = 1'b0;
        while (idx < 64 && t < 5000) begin
            out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            if (out_valid) begin
                if (holding) begin
                    check("hold_data", out_data, held_d);
                    check("hold_last", out_last, held_l);
                end
                if (out_ready) begin
                    check("out_byte", out_data, exp_oh[511 - 8*idx -: 8]);
                    check("out_last", out_last, (idx == 63));
                    idx++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held_d  = out_data;
                    held_l  = out_last;
                end
            end
            @(posedge clk); #1; t++;
        end
        out_ready = 1'b0;
        check("recv_count", idx, 64);
    endtask

    // Everything after the load: config, hold length, done latency, result
    task automatic finish_job(input logic [511:0] oh, input bit rand_ready);
        int n;
        core_oH = oh;
        check("core_mode", core_mode, hdr_b[0]);
        check("core_key", core_key, model_key());
        check("core_msg", core_msg, model_msg());
        check("in_ready_hold", in_ready, 1'b0);
        wait_run(n);
        check("hold_cycles", n, 32);
        n = 0;
        while (!core_done && n < 200) begin @(posedge clk); #1; n++; end
        check("done_seen", core_done, 1'b1);
        check("valid_at_done", out_valid, 1'b0);
        @(posedge clk); #1;
        check("valid_after_done", out_valid, 1'b1);
        check("core_reset_send", core_reset, 1'b0);
        recv_job(oh, rand_ready);
        check("busy_after", busy, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
        check("err_after", err, 1'b0);
        check("key_stable", core_key, model_key());
        check("msg_stable", core_msg, model_msg());
    endtask

    task automatic run_job(input logic [7:0] hdr, input int gap, input logic [511:0] oh, input bit rand_ready);
        hdr_b = hdr;
        send_byte(hdr, gap);
        check("busy_hdr", busy, 1'b1);
        check("err_hdr", err, 1'b0);
        send_body(gap);
        finish_job(oh, rand_ready);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 128; i++) kb[i] = 8'($urandom);
        for (int i = 0; i < 64; i++)  mb[i] = 8'($urandom);
        for (int i = 0; i < 16; i++)  oh_v[32*i +: 32] = $urandom;
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        core_oH   = 512'd0;
        hdr_b     = 8'd0;
        oh_v      = 512'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_core_reset", core_reset, 1'b0);
        check("rst_core_mode", core_mode, 1'b0);
        check("rst_core_key", core_key, 1024'd0);
        check("rst_core_msg", core_msg, 512'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1'b1);

        // Byte ordering + full job with directed data
        for (int i = 0; i < 128; i++) kb[i] = 8'(i);
        for (int i = 0; i < 64; i++)  mb[i] = 8'(8'h80 + i);
        for (int i = 0; i < 64; i++)  oh_v[511 - 8*i -: 8] = 8'(i);
        hdr_b = 8'h01;
        send_byte(8'h01, 0);
        send_body(0);
        check("key_msb", core_key[1023:1016], 8'h00);
        check("key_lsb", core_key[7:0], 8'h7F);
        check("msg_msb", core_msg[511:504], 8'h80);
        check("msg_lsb", core_msg[7:0], 8'hBF);
        finish_job(oh_v, 1'b0);

        // Same job with input gaps and 50% sink backpressure
        run_job(8'h01, 3, oh_v, 1'b1);

        // Back-to-back random jobs with different keys
        rand_data();
        run_job(8'hFE, 0, oh_v, 1'b0);
        rand_data();
        run_job(8'h03, 1, oh_v, 1'b1);

        // Reset pulse 5 cycles into RUN, then a full job
        rand_data();
        hdr_b = 8'h01;
        core_oH = oh_v;
        send_byte(8'h01, 0);
        send_body(0);
        wait_run(n);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_in_ready", in_ready, 1'b0);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_core_reset", core_reset, 1'b0);
        check("mid_core_key", core_key, 1024'd0);
        check("mid_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_in_ready", in_ready, 1'b1);
        rand_data();
        run_job(8'h00, 0, oh_v, 1'b1);

`ifdef HMAC_DRV_TIMEOUT_EN
        // Watchdog: stub never reports done
        never_done = 1'b1;
        rand_data();
        hdr_b = 8'h01;
        send_byte(8'h01, 0);
        send_body(0);
        wait_run(n);
        n = 0;
        while (!err && n < 300) begin @(posedge clk); #1; n++; end
        check("timeout_cycles", n, 100);
        check("timeout_core_reset", core_reset, 1'b0);
        check("timeout_valid", out_valid, 1'b1);
        recv_job(512'd0, 1'b1);
        check("timeout_err_sticky", err, 1'b1);
        never_done = 1'b0;
        rand_data();
        hdr_b = 8'h00;
        send_byte(8'h00, 0);
        check("timeout_err_clear", err, 1'b0);
        send_body(0);
        finish_job(oh_v, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hmac_stream_driver.md
Name: hmac_stream_driver

Overview:
- Host-side front end for the hmac core.
- Collects one job from a byte stream: a mode header, the 1024-bit key and the 512-bit message.
- Presents the job to the core, releases the core's active-low reset to start it, and waits for done.
- Streams the 512-bit result oH back out as bytes. One job is in flight at a time.

Parameters:
- HOLD_CYCLES, 32: minimum cycles core_reset is held low after load completes, before the run starts.
- TIMEOUT_CYCLES, 4096: watchdog limit in RUN (used only with HMAC_DRV_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input byte valid.
- in_ready  output  1  driver can accept an input byte.
- in_data  input  8  input byte.
- out_valid  output  1  result byte valid.
- out_ready  input  1  sink accepts the result byte.
- out_data  output  8  result byte.
- out_last  output  1  marks the final (64th) result byte.
- busy  output  1  high from the first accepted header byte until the last result byte is accepted.
- err  output  1  sticky watchdog flag; cleared by the next accepted header byte.
- core_reset  output  1  drives the hmac reset; 0 holds the core idle, 1 runs it.
- core_done  input  1  hmac done.
- core_mode  output  1  hmac mode.
- core_key  output  1024  hmac key.
- core_msg  output  512  hmac message.
- core_oH  input  512  hmac result.

Behaviour:
- Reset values (reset low): in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0, core_reset=0, core_mode=0, core_key=0, core_msg=0. All counters are 0 and the state is LOAD_HDR.
- Transfer rule: an input byte transfers on a posedge with in_valid&&in_ready; an output byte transfers with out_valid&&out_ready.
- in_ready is 1 exactly in LOAD_HDR, LOAD_KEY and LOAD_MSG.
- LOAD_HDR:
  - Accepts 1 byte; core_mode <= in_data[0]; bits [7:1] are ignored.
  - On transfer, sets busy=1 and err=0, clears the byte counter, and moves to LOAD_KEY.
- LOAD_KEY:
  - Accepts 128 bytes, MSB first: core_key <= {core_key[1015:0], in_data}.
  - After byte 128, moves to LOAD_MSG.
- LOAD_MSG:
  - Accepts 64 bytes the same way into core_msg.
  - After byte 64, moves to HOLD.
- HOLD:
  - Holds core_reset=0 for exactly HOLD_CYCLES cycles, then moves to RUN.
  - core_reset goes to 1 on the posedge that enters RUN.
- RUN:
  - Holds core_reset=1.
  - core_done is ignored in the first RUN cycle and sampled from the second cycle onward.
  - On the first sampled core_done=1: capture core_oH into the result shift register, set core_reset<=0, and move to SEND.
  - out_valid rises on that same posedge, i.e. one cycle after done is seen.
- SEND:
  - out_valid=1 and out_data=sr[511:504].
  - On each output transfer: shift sr left by 8 and increment the byte counter.
  - out_last=1 while the counter is 63.
  - After byte 64 transfers: out_valid=0, busy=0, return to LOAD_HDR. The next job can be accepted the following cycle.
- Output hold: while out_ready=0, out_data and out_last hold.
- Input gaps: gaps in in_valid stall the load with no state change.
- Configuration stability: core_key, core_msg and core_mode stay stable from the end of load until SEND exits. They are never cleared between jobs, only overwritten.
- Asynchronous reset in any state (including mid-RUN or mid-SEND):
  - All outputs return to their reset values immediately, with core_reset forced 0.
  - A partial job is discarded.
- A core_done seen outside RUN has no effect.

Optional Feature:
- HMAC_DRV_TIMEOUT_EN defined:
  - A 32-bit watchdog counts RUN cycles.
  - If it reaches TIMEOUT_CYCLES without a sampled core_done:
    - err<=1 (sticky) and core_reset<=0;
    - the driver moves to SEND, which emits 64 bytes of 0x00 with out_last on the final byte;
    - then it returns to LOAD_HDR.
- HMAC_DRV_TIMEOUT_EN undefined: no watchdog logic, err is tied 0, and RUN waits indefinitely.

Test Plan:
- Reset check: assert reset low mid-stream -> in_ready=0, out_valid=0, core_reset=0, core_key=0, busy=0. Release -> in_ready=1 on the next cycle.
- Byte ordering: header 0x01, key bytes 0x00..0x7F, msg bytes 0x80..0xBF. Expected:
  - core_mode=1;
  - core_key[1023:1016]=0x00 and core_key[7:0]=0x7F;
  - core_msg[511:504]=0x80 and core_msg[7:0]=0xBF;
  - core_reset stays low for exactly 32 cycles after the last byte, then goes high.
- Full job: a stub core raises done 10 cycles after core_reset rises, with oH = 0x00,0x01..0x3F (MSB first). Expected:
  - out_valid rises 1 cycle after done;
  - the byte sequence 0x00..0x3F is emitted, with out_last only on 0x3F;
  - core_reset=0 during SEND.
- Backpressure: randomize in_valid gaps and toggle out_ready 50% -> identical core_key/core_msg and output bytes to the no-gap run; out_data holds while out_ready=0.
- Back-to-back and reset mid-RUN:
  - Run two jobs with different keys -> the second result is correct and busy drops between them.
  - Pulse reset low 5 cycles into RUN -> state is LOAD_HDR and a subsequent full job completes correctly.
- Timeout (HMAC_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=100): stub never asserts done. Expected:
  - err=1 at RUN cycle 100;
  - 64 zero bytes are emitted;
  - err clears on the next header byte.
